// File: rtl/trap_filter_pz.sv
// trap_filter_pz: reloadable trapezoidal shaper with pole-zero correction,
// saturating output, sticky overflow and threshold peak detector.
// Latency 4 cycles input_valid -> output_valid; no backpressure: every valid
// sample is taken except during a config flush, where samples are dropped.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   input_data / input_valid   unsigned ADC sample and its strobe
//   cfg_k/l/m/shift, cfg_load  run-time coefficients and reload request
//   threshold                  signed peak-detector threshold
//   cfg_busy / cfg_err         flush in progress / illegal config rejected
//   output_data / output_valid signed saturated shaped sample and strobe
//   peak_data / peak_valid     excursion maximum and its 1-cycle strobe
//   overflow                   sticky saturation flag
module trap_filter_pz #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 64,
  parameter int KL_W   = 7,
  parameter int M_W    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       input_data,
  input  logic                    input_valid,
  input  logic [KL_W-1:0]         cfg_k,
  input  logic [KL_W-1:0]         cfg_l,
  input  logic [M_W-1:0]          cfg_m,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_load,
  input  logic signed [OUT_W-1:0] threshold,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  output logic signed [OUT_W-1:0] output_data,
  output logic                    output_valid,
  output logic signed [OUT_W-1:0] peak_data,
  output logic                    peak_valid,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int D_W   = DATA_W + 2;
  localparam int MD_W  = M_W + 1 + D_W;
  localparam logic [KL_W:0]      DEPTH_C = (KL_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(DEPTH - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic                     load_ok, err_d, flush_now, accept;

  logic [KL_W-1:0]          k_q, l_q;
  logic [M_W-1:0]           m_q;
  logic [4:0]               shift_q;
  logic                     cfg_err_q;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_q;
  logic [KL_W:0]            fill_q;

  logic                     v1_q, v2_q, v3_q, out_vld_q;
  logic signed [D_W-1:0]    d_q;
  logic signed [ACC_W-1:0]  p_q, md_q, r_q, s_q;
  logic signed [OUT_W-1:0]  out_dat_q;

  logic                     armed_q, armed_d, pk_vld_q, pk_vld_d, ovf_q;
  logic signed [OUT_W-1:0]  max_q, max_d, pk_dat_q, pk_dat_d;

  // Config legality: 1 <= k <= l and k + l fits in the delay line.
  logic [KL_W:0] new_sum;
  logic          cfg_legal;
  assign new_sum   = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_legal = (cfg_k != '0) && (cfg_k <= cfg_l) && (new_sum <= DEPTH_C);

  always_comb begin
    state_d = state_q;
    load_ok = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_load) begin
          if (cfg_legal) begin
            load_ok = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // The accepting cycle and the flush cycle both squash in-flight samples.
  assign flush_now = load_ok || (state_q == ST_FLUSH);
  assign accept    = input_valid && !flush_now;

  // Delay-line taps. A tap reads zero until that many samples have been
  // written, so stale RAM contents never leak after a flush. Distance DEPTH
  // lands on wr_q itself, which still holds the oldest sample this cycle.
  logic [KL_W:0]      k_ext, l_ext, kl_ext;
  logic [PTR_W-1:0]   a_k, a_l, a_kl;
  logic [DATA_W-1:0]  x_k, x_l, x_kl;
  logic signed [D_W-1:0] d_c;
  assign k_ext  = {1'b0, k_q};
  assign l_ext  = {1'b0, l_q};
  assign kl_ext = k_ext + l_ext;
  assign a_k    = wr_q - PTR_W'(k_ext);
  assign a_l    = wr_q - PTR_W'(l_ext);
  assign a_kl   = wr_q - PTR_W'(kl_ext);
  assign x_k    = (fill_q >= k_ext)  ? mem_q[a_k]  : '0;
  assign x_l    = (fill_q >= l_ext)  ? mem_q[a_l]  : '0;
  assign x_kl   = (fill_q >= kl_ext) ? mem_q[a_kl] : '0;
  assign d_c    = $signed({2'b00, input_data}) - $signed({2'b00, x_k})
                - $signed({2'b00, x_l}) + $signed({2'b00, x_kl});

  logic signed [MD_W-1:0]  md_c;
  logic signed [ACC_W-1:0] s_c, sh_c;
  logic [ACC_W-OUT_W:0]    hi_c;
  logic                    sat_pos, sat_neg;
  logic signed [OUT_W-1:0] o_c;
  assign md_c = $signed({1'b0, m_q}) * d_q;
  assign s_c  = s_q + r_q;
  assign sh_c = s_c >>> shift_q;
  // In range only when every bit above the output sign bit matches it.
  assign hi_c    = sh_c[ACC_W-1:OUT_W-1];
  assign sat_pos = !sh_c[ACC_W-1] && (|hi_c);
  assign sat_neg =  sh_c[ACC_W-1] && !(&hi_c);
  assign o_c = sat_pos ? {1'b0, {(OUT_W-1){1'b1}}} :
               sat_neg ? {1'b1, {(OUT_W-1){1'b0}}} : sh_c[OUT_W-1:0];

  always_comb begin
    armed_d  = armed_q;
    max_d    = max_q;
    pk_vld_d = 1'b0;
    pk_dat_d = pk_dat_q;
    if (v3_q) begin
      if (o_c > threshold) begin
        armed_d = 1'b1;
        if (o_c > max_q) max_d = o_c;
      end else if (armed_q) begin
        pk_vld_d = 1'b1;
        pk_dat_d = max_q;
        armed_d  = 1'b0;
        max_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) mem_q[wr_q] <= input_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cfg_err_q <= 1'b0;
      k_q       <= KL_W'(4);
      l_q       <= KL_W'(6);
      m_q       <= '0;
      shift_q   <= '0;
      wr_q      <= '0;
      fill_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_vld_q <= 1'b0;
      d_q       <= '0;
      p_q       <= '0;
      md_q      <= '0;
      r_q       <= '0;
      s_q       <= '0;
      out_dat_q <= '0;
      armed_q   <= 1'b0;
      max_q     <= '0;
      pk_vld_q  <= 1'b0;
      pk_dat_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= err_d;
      if (load_ok) begin
        k_q     <= cfg_k;
        l_q     <= cfg_l;
        m_q     <= cfg_m;
        shift_q <= cfg_shift;
      end
      v1_q <= accept;
      if (accept) begin
        d_q    <= d_c;
        wr_q   <= (wr_q == PTR_MAX) ? '0 : wr_q + PTR_W'(1);
        fill_q <= (fill_q == DEPTH_C) ? fill_q : fill_q + (KL_W+1)'(1);
      end
      if (flush_now) begin
        fill_q    <= '0;
        v2_q      <= 1'b0;
        v3_q      <= 1'b0;
        out_vld_q <= 1'b0;
        p_q       <= '0;
        s_q       <= '0;
        armed_q   <= 1'b0;
        max_q     <= '0;
        pk_vld_q  <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          p_q  <= p_q + {{(ACC_W-D_W){d_q[D_W-1]}}, d_q};
          md_q <= {{(ACC_W-MD_W){md_c[MD_W-1]}}, md_c};
        end
        v3_q <= v2_q;
        if (v2_q) r_q <= p_q + md_q;
        out_vld_q <= v3_q;
        if (v3_q) begin
          s_q       <= s_c;
          out_dat_q <= o_c;
          if (sat_pos || sat_neg) ovf_q <= 1'b1;
        end
        armed_q  <= armed_d;
        max_q    <= max_d;
        pk_vld_q <= pk_vld_d;
        pk_dat_q <= pk_dat_d;
      end
    end
  end

  assign cfg_busy     = (state_q == ST_FLUSH);
  assign cfg_err      = cfg_err_q;
  assign output_data  = out_dat_q;
  assign output_valid = out_vld_q;
  assign peak_data    = pk_dat_q;
  assign peak_valid   = pk_vld_q;
  assign overflow     = ovf_q;

endmodule
